alu_issue_queue: RTL and testbench

//  Upstream operand/command stage for the 16-bit ALU. Buffers {opcode, X, Y} commands in a small FIFO
//  and issues them to the ALU one at a time: drives X/Y/Opcode stable, pulses Enable for one cycle,

---
 rtl/alu_issue_queue_if.sv | 45 ++++
 rtl/alu_issue_queue.sv | 133 +++++++++++++
 tb/tb_alu_issue_queue.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Bundle between the ALU issue queue and its surroundings: command push side,
// ALU operand/result side, result handshake side and status.
interface alu_issue_queue_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // command push
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [DATA_W-1:0] cmd_x;
  logic [DATA_W-1:0] cmd_y;
  // ALU side
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic [2:0]        Opcode;
  logic              Enable;
  logic [DATA_W-1:0] Results;
  logic              CF;
  // result slot
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_cf;
  logic [2:0]        res_opcode;
  // status
  logic              busy;
  logic [CNT_W-1:0]  count;

  // queue side
  modport master (
    input  cmd_valid, cmd_opcode, cmd_x, cmd_y, Results, CF, res_ready,
    output cmd_ready, X, Y, Opcode, Enable, res_valid, res_data, res_cf,
           res_opcode, busy, count
  );

  // producer / ALU / consumer side
  modport slave (
    output cmd_valid, cmd_opcode, cmd_x, cmd_y, Results, CF, res_ready,
    input  cmd_ready, X, Y, Opcode, Enable, res_valid, res_data, res_cf,
           res_opcode, busy, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers {opcode,X,Y} commands in a small FIFO and issues
// them to the ALU one at a time (operands settle, one-cycle Enable, wait for
// the result), then parks the result in a single valid/ready slot.
module alu_issue_queue #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int RESULT_LAT   = 1
) (
  input logic          CLK,
  input logic          RST,
  alu_issue_queue_if.master bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (SETUP_CYCLES > RESULT_LAT) ? SETUP_CYCLES : RESULT_LAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, FIRE, WAIT} state_t;

  cmd_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [DATA_W-1:0] x_q, y_q, res_data_q;
  logic [2:0]        op_q, res_op_q;
  logic              en_q, res_valid_q, res_cf_q;
  logic              push, pop, capture, res_take;

  // ready depends on occupancy only: a full FIFO refuses even if it pops this cycle
  assign bus.cmd_ready = (count_q < CNT_W'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // only issue when the result slot is free or is being drained this edge
  assign pop           = (state == IDLE) && (count_q != '0) && (!res_valid_q || bus.res_ready);
  assign capture       = (state == WAIT) && (tmr == '0);
  assign res_take      = res_valid_q && bus.res_ready;

  assign bus.X          = x_q;
  assign bus.Y          = y_q;
  assign bus.Opcode     = op_q;
  assign bus.Enable     = en_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_cf     = res_cf_q;
  assign bus.res_opcode = res_op_q;
  assign bus.count      = count_q;
  assign bus.busy       = (state != IDLE) || (count_q != '0);

  // command storage write
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{opcode: bus.cmd_opcode, x: bus.cmd_x, y: bus.cmd_y};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // issue sequencer: operands latched on pop, Enable registered for exactly the FIRE cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      tmr   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      op_q  <= '0;
      en_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            x_q   <= mem[rd_ptr].x;
            y_q   <= mem[rd_ptr].y;
            op_q  <= mem[rd_ptr].opcode;
            tmr   <= TMR_W'(SETUP_CYCLES - 1);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            en_q  <= 1'b1;
            state <= FIRE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        FIRE: begin
          en_q  <= 1'b0;
          tmr   <= TMR_W'(RESULT_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (tmr == '0) state <= IDLE;
          else           tmr   <= tmr - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // result slot: a capture on the same edge as a take keeps the slot full
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cf_q    <= 1'b0;
      res_op_q    <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bus.Results;
      res_cf_q    <= bus.CF;
      res_op_q    <= op_q;
    end else if (res_take) begin
      res_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed commands with hand-computed results,
// a scoreboard queue filled on accept and drained by an independent monitor.
module tb_alu_issue_queue;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_issue_queue_if #(.DATA_W(16), .DEPTH(4)) bus();

  alu_issue_queue #(
    .DATA_W(16), .DEPTH(4), .SETUP_CYCLES(1), .RESULT_LAT(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [19:0] exp_q[$];        // {data, cf, opcode}
  logic [19:0] mon_exp;
  bit          push_done;

  // burst table for the backpressure/order test
  logic [2:0]  t3_op [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
  logic [15:0] t3_x  [6] = '{16'h0010, 16'h0003, 16'hF0F0, 16'h00F0, 16'hAAAA, 16'h1234};
  logic [15:0] t3_y  [6] = '{16'h0020, 16'h0005, 16'hFF00, 16'h0F00, 16'hFFFF, 16'h5678};
  logic [15:0] t3_d  [6] = '{16'h0030, 16'hFFFE, 16'hF000, 16'h0FF0, 16'h5555, 16'h0000};
  logic        t3_c  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always @(posedge CLK) cyc <= cyc + 1;

  // ALU model: result registered on the edge that samples Enable
  always @(posedge CLK) begin
    if (RST) begin
      bus.Results <= '0;
      bus.CF      <= 1'b0;
    end else if (bus.Enable) begin
      case (bus.Opcode)
        3'b001:  {bus.CF, bus.Results} <= {1'b0, bus.X} + {1'b0, bus.Y};
        3'b010:  {bus.CF, bus.Results} <= {1'b0, bus.X} - {1'b0, bus.Y};
        3'b011:  {bus.CF, bus.Results} <= {1'b0, bus.X & bus.Y};
        3'b100:  {bus.CF, bus.Results} <= {1'b0, bus.X | bus.Y};
        3'b101:  {bus.CF, bus.Results} <= {1'b0, bus.X ^ bus.Y};
        default: {bus.CF, bus.Results} <= 17'h0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // monitor: every result the consumer takes is checked against the scoreboard
  always @(negedge CLK) begin
    if (!RST && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h, want none",
                 {bus.res_data, bus.res_cf, bus.res_opcode});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", {12'h0, bus.res_data, bus.res_cf, bus.res_opcode}, {12'h0, mon_exp});
      end
    end
  end

  // drive at negedge so consecutive calls land on consecutive edges
  task automatic push_cmd(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] ed, input logic ecf);
    int w = 0;
    @(negedge CLK);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_x      = x;
    bus.cmd_y      = y;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got cmd_ready=%0b, want 1", bus.cmd_ready);
    end else begin
      exp_q.push_back({ed, ecf, op});
    end
    @(posedge CLK);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge CLK);
    while ((bus.busy || bus.res_valid) && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("idle_reached", {30'h0, bus.busy, bus.res_valid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int enables;
    int takes [6];
    int nt;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_x      = '0;
    bus.cmd_y      = '0;
    bus.res_ready  = 1'b1;

    // reset state
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_enable", bus.Enable, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_x", bus.X, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // single add: Enable on cycle 2, result on cycle 4 after accept
    push_cmd(3'b001, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    @(negedge CLK);
    chk("t1_count", bus.count, 1);
    chk("t1_busy", bus.busy, 1);
    @(negedge CLK);
    chk("t1_x", bus.X, 16'h0003);
    chk("t1_y", bus.Y, 16'h0004);
    chk("t1_en_setup", bus.Enable, 0);
    @(negedge CLK);
    chk("t1_en_fire", bus.Enable, 1);
    @(negedge CLK);
    chk("t1_en_wait", bus.Enable, 0);
    chk("t1_rv_wait", bus.res_valid, 0);
    @(negedge CLK);
    chk("t1_rv", bus.res_valid, 1);
    wait_idle();

    // carry out; operands held while idle
    push_cmd(3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    wait_idle();
    chk("t2_x_hold", bus.X, 16'hFFFF);
    chk("t2_y_hold", bus.Y, 16'h0001);
    chk("t2_op_hold", bus.Opcode, 3'b001);

    // six back-to-back with result stalled, then release
    bus.res_ready = 1'b0;
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push_cmd(t3_op[i], t3_x[i], t3_y[i], t3_d[i], t3_c[i]);
        push_done = 1'b1;
      end
    join_none
    w = 0;
    @(negedge CLK);
    while (bus.count != 4 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    chk("t3_full", bus.count, 4);
    chk("t3_not_ready", bus.cmd_ready, 0);
    repeat (5) @(negedge CLK);
    chk("t3_still_full", bus.count, 4);
    chk("t3_sixth_held", {31'h0, push_done}, 0);
    chk("t3_rv_held", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    nt = 0;
    w  = 0;
    while (nt < 6 && w < 100) begin
      if (bus.res_valid && bus.res_ready) begin
        takes[nt] = cyc;
        nt++;
      end
      @(negedge CLK);
      w++;
    end
    chk("t3_all_taken", nt, 6);
    for (int k = 1; k < 6; k++) chk("t3_spacing", takes[k] - takes[k-1], 4);
    chk("t3_push_done", {31'h0, push_done}, 1);
    wait_idle();

    // result backpressure: slot holds, second command not issued
    bus.res_ready = 1'b0;
    push_cmd(3'b011, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0);
    push_cmd(3'b101, 16'h1234, 16'h1234, 16'h0000, 1'b0);
    w = 0;
    while (bus.res_valid !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    enables = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (bus.Enable) enables++;
      chk("t4_rv", bus.res_valid, 1);
      chk("t4_data", bus.res_data, 16'h000F);
    end
    chk("t4_no_enable", enables, 0);
    chk("t4_count", bus.count, 1);
    bus.res_ready = 1'b1;
    wait_idle();

    // reset during FIRE: op abandoned, nothing comes back
    push_cmd(3'b001, 16'h0101, 16'h0202, 16'h0303, 1'b0);
    w = 0;
    @(negedge CLK);
    while (bus.Enable !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("t5_in_fire", bus.Enable, 1);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("t5_enable", bus.Enable, 0);
    chk("t5_res_valid", bus.res_valid, 0);
    chk("t5_count", bus.count, 0);
    chk("t5_x", bus.X, 0);
    chk("t5_y", bus.Y, 0);
    repeat (8) @(negedge CLK);
    chk("t5_no_stale", bus.res_valid, 0);

    // push and pop on the same edge with count=2
    bus.res_ready = 1'b0;
    push_cmd(3'b001, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    push_cmd(3'b001, 16'h0002, 16'h0002, 16'h0004, 1'b0);
    push_cmd(3'b001, 16'h0003, 16'h0003, 16'h0006, 1'b0);
    w = 0;
    while (bus.res_valid !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("t6_count_pre", bus.count, 2);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 3'b001;
    bus.cmd_x      = 16'h0004;
    bus.cmd_y      = 16'h0004;
    bus.res_ready  = 1'b1;
    chk("t6_ready", bus.cmd_ready, 1);
    exp_q.push_back({16'h0008, 1'b0, 3'b001});
    @(posedge CLK);
    #1 bus.cmd_valid = 1'b0;
    @(negedge CLK);
    chk("t6_count_same", bus.count, 2);
    wait_idle();
    wait_idle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
